io_uart_tx: RTL
===============

Name: io_uart_tx

Overview:
- Downstream consumer of the CPU's memory-mapped output port (`io_write` / `io_data`, pulsed on a store to address 0xFF).
- Buffers the 64-bit words in a FIFO and serialises each word onto a UART 8N1 line, so CPU output is observable on a pin.
- The CPU has no backpressure, so the block absorbs bursts and reports loss through a sticky overflow flag.

Parameters:
- DEPTH, 8, FIFO depth in 64-bit words; power of two, at least 2.
- CLKS_PER_BIT, 16, clock cycles per UART bit; at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- io_write  input  1  one-cycle write strobe from the CPU.
- io_data  input  64  word to send; sampled when io_write=1.
- tx  output  1  UART serial line; idles high.
- busy  output  1  1 while the serialiser is not IDLE or the FIFO is non-empty.
- fifo_count  output  $clog2(DEPTH)+1  words currently held in the FIFO.
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst); it is sampled on the rising edge of clk.
- Reset values: tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE. Pointers, byte index and bit/baud counters are cleared.
- Reset mid-frame: tx=1 from the reset edge onward, and FIFO contents are discarded.
- FIFO push: on an edge with io_write=1 and fifo_count<DEPTH, io_data is written at wr_ptr and wr_ptr increments.
- Fullness is judged on the pre-edge count. A write while full is dropped and overflow is set to 1, even if a pop occurs on the same edge.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop: fifo_count is unchanged.
- overflow clears only on rst.
- State machine: IDLE -> LOAD -> START -> DATA -> STOP, then either START (more bytes remain) or IDLE.
  - IDLE: if fifo_count>0, pop the head word into a 64-bit shift register, set byte_idx=0, go to LOAD.
  - LOAD: select the current byte; go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<7, increment byte_idx, shift the word right by 8 and go to START; else go to IDLE.
- Byte order: little-endian, io_data[7:0] first, io_data[63:56] last.
- Frame length: one word = 8 frames × 10 bits × CLKS_PER_BIT cycles. There are no idle bits between the bytes of a word.
- After STOP of the final byte, the FSM passes through IDLE for one cycle before the next word's LOAD.
- Latency: io_write sampled at edge E with the block idle and FIFO empty:
  - word enters the FIFO at E;
  - popped at E+1 (IDLE -> LOAD);
  - tx falls at E+2 (LOAD -> START).
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs when the counter equals CLKS_PER_BIT-1.
- busy=1 from the edge after the push until the edge on which the FSM returns to IDLE with an empty FIFO.
- tx is driven from a register, with no combinational path from any input.

Optional Feature:
- Macro IO_UART_TX_HEX_EN.
- When defined: each word is sent as 17 ASCII characters instead of 8 raw bytes.
  - The first 16 characters are hex digits, MSB nibble first: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
  - The 17th character is newline 0x0A.
  - byte_idx runs 0..16 and the shift register shifts left by 4 per character.
- When undefined: raw 8-byte little-endian mode as above.
- Framing, FIFO, latency and reset behaviour are identical in both modes.

Test Plan:
- Single word, CLKS_PER_BIT=4, raw mode: io_write with io_data=0x0807060504030201.
  - Decoded bytes are 01, 02, …, 08 in that order.
  - tx low at E+2; busy drops 320+2 cycles later.
  - fifo_count returns to 0.
- Overflow, DEPTH=4, raw mode: io_write on 6 consecutive cycles with data 1..6.
  - Words 1..5 are transmitted, word 6 never appears.
  - overflow=1 stays set after busy=0.
  - Peak fifo_count is 4.
- Back-to-back words: two writes 0x11…11 and 0x22…22 (all-0x11, all-0x22) spaced 3 cycles apart.
  - 16 frames are sent: eight 0x11 then eight 0x22.
  - Gap between the words' frames is exactly 2 cycles (IDLE + LOAD).
- Push while popping: with fifo_count=2, io_write on the same edge as IDLE pops.
  - fifo_count stays 2 and no overflow.
- Reset mid-frame: assert rst during the DATA bit 3 of byte 2.
  - tx=1, fifo_count=0, overflow=0 and busy=0 from the reset edge onward.
  - The first io_write after reset produces a clean frame at E+2.
- Hex mode (IO_UART_TX_HEX_EN): io_data=0x00000000DEADBEEF.
  - Line carries "00000000DEADBEEF\n", i.e. 0x30 ×8, then 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0A.

Source files
------------

// File: rtl/io_uart_tx.sv
// Buffers 64-bit CPU output words in a FIFO and serialises them onto a UART 8N1 line.
// Define IO_UART_TX_HEX_EN to send each word as 16 uppercase hex digits plus newline instead of 8 raw bytes.
module io_uart_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     io_write,
    input  logic [63:0]              io_data,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef IO_UART_TX_HEX_EN
    localparam logic [4:0] LAST_IDX = 5'd16;
`else
    localparam logic [4:0] LAST_IDX = 5'd7;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [63:0]   shreg;
    logic [4:0]    byte_idx;
    logic [2:0]    bit_idx;
    logic [CW-1:0] baud;
    logic [7:0]    cur_char;
    logic          full;
    logic          push;
    logic          pop;
    logic          bit_end;

    // Fullness uses the pre-edge count, so a pop on the same edge never rescues a write.
    assign full    = (fifo_count == (PW+1)'(DEPTH));
    assign push    = io_write && !full;
    assign pop     = (state == IDLE) && (fifo_count != '0);
    assign bit_end = (baud == CW'(CLKS_PER_BIT - 1));
    assign busy    = (state != IDLE) || (fifo_count != '0);

    always_comb begin
`ifdef IO_UART_TX_HEX_EN
        if (byte_idx == 5'd16)
            cur_char = 8'h0A;
        else if (shreg[63:60] < 4'd10)
            cur_char = {4'h3, shreg[63:60]};
        else
            cur_char = {4'h3, shreg[63:60]} + 8'd7;
`else
        cur_char = shreg[7:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= io_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            tx         <= 1'b1;
            shreg      <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            baud       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (io_write && full)
                overflow <= 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        byte_idx <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    tx    <= 1'b0;
                    baud  <= '0;
                    state <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= cur_char[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_char[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (byte_idx != LAST_IDX) begin
                            // Next character starts immediately: no idle bits inside a word.
                            byte_idx <= byte_idx + 5'd1;
`ifdef IO_UART_TX_HEX_EN
                            shreg    <= {shreg[59:0], 4'h0};
`else
                            shreg    <= {8'h00, shreg[63:8]};
`endif
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
